eth_tx_pktbuf: RTL and testbench

- Store-and-forward frame buffer between the Ethernet encapsulator's 64-bit AXI-stream TX output and the 10G MAC TX input, in the eth_clk domain.
- Releases a frame to the MAC only after the whole frame is stored, so the MAC never underruns mid-frame when the TLP FIFO stalls.
- Drops frames that do not fit, rather than back-pressuring the encapsulator mid-frame.
- Keeps frame and drop counters for the adapter register block.

---
 rtl/eth_tx_pktbuf.sv | 210 +++++++++++++++++++++
 tb/tb_eth_tx_pktbuf.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_pktbuf.sv
// rtl/eth_tx_pktbuf.sv - store-and-forward TX frame buffer between encapsulator and 10G MAC
// ETH_TX_PAD_EN: read side zero-pads frames shorter than 60 bytes.
module eth_tx_pktbuf #(
   parameter int DEPTH  = 512,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              eth_clk,
   input  logic              eth_rst_n,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic              s_tlast,
   input  logic [7:0]        s_tkeep,
   input  logic [63:0]       s_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic [7:0]        m_tkeep,
   output logic [63:0]       m_tdata,
   output logic              m_tuser,
   output logic [31:0]       frame_cnt,
   output logic [31:0]       drop_cnt,
   output logic [ADDR_W:0]   buf_level
);

   localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {RX_IDLE, RX_STORE, RX_DROP} rx_state_t;

   logic [72:0]     mem [DEPTH];
   rx_state_t       rx_state_q, rx_state_d;
   logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d;
   logic [ADDR_W:0] rd_ptr_q, rd_ptr_d, ft_ptr_q, ft_ptr_d;
   logic [31:0]     frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
   logic            m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
   logic            out_ram_q, out_ram_d;
   logic [7:0]      m_tkeep_q, m_tkeep_d;
   logic [63:0]     m_tdata_q, m_tdata_d;
   logic            has_space, wr_en, avail, load_en;
   logic [72:0]     rd_word;
`ifdef ETH_TX_PAD_EN
   logic            pad_q, pad_d;
   logic [3:0]      bidx_q, bidx_d;
   logic [63:0]     rd_masked;
`endif

   // rd_ptr only advances when a stored beat leaves on the wire, so the beat
   // parked in the output register still counts as occupied.
   assign has_space = !((wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                        (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]));
   assign avail     = (ft_ptr_q != wr_commit_q);
   assign load_en   = !m_tvalid_q || m_tready;
   assign rd_word   = mem[ft_ptr_q[ADDR_W-1:0]];

   always_comb begin
      rx_state_d  = rx_state_q;
      wr_ptr_d    = wr_ptr_q;
      wr_commit_d = wr_commit_q;
      drop_cnt_d  = drop_cnt_q;
      wr_en       = 1'b0;
      if (s_tvalid) begin
         case (rx_state_q)
            RX_IDLE, RX_STORE: begin
               if (has_space) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_ONE;
                  if (s_tlast) begin
                     wr_commit_d = wr_ptr_q + PTR_ONE;
                     rx_state_d  = RX_IDLE;
                  end else begin
                     rx_state_d  = RX_STORE;
                  end
               end else begin
                  wr_ptr_d   = wr_commit_q;
                  drop_cnt_d = drop_cnt_q + 32'd1;
                  rx_state_d = s_tlast ? RX_IDLE : RX_DROP;
               end
            end
            default: begin
               if (s_tlast) rx_state_d = RX_IDLE;
            end
         endcase
      end
   end

`ifdef ETH_TX_PAD_EN
   always_comb begin
      rd_masked = rd_word[63:0];
      for (int b = 0; b < 8; b++) begin
         if (!rd_word[64+b]) rd_masked[8*b +: 8] = 8'h00;
      end
   end
`endif

   always_comb begin
      m_tvalid_d  = m_tvalid_q;
      m_tlast_d   = m_tlast_q;
      m_tkeep_d   = m_tkeep_q;
      m_tdata_d   = m_tdata_q;
      out_ram_d   = out_ram_q;
      rd_ptr_d    = rd_ptr_q;
      ft_ptr_d    = ft_ptr_q;
      frame_cnt_d = frame_cnt_q;
`ifdef ETH_TX_PAD_EN
      pad_d       = pad_q;
      bidx_d      = bidx_q;
`endif
      if (m_tvalid_q && m_tready) begin
         if (out_ram_q) rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (m_tlast_q) frame_cnt_d = frame_cnt_q + 32'd1;
      end
      if (load_en) begin
         m_tvalid_d = 1'b0;
`ifdef ETH_TX_PAD_EN
         if (pad_q) begin
            m_tvalid_d = 1'b1;
            out_ram_d  = 1'b0;
            m_tdata_d  = 64'd0;
            if (bidx_q == 4'd7) begin
               m_tkeep_d = 8'h0F;
               m_tlast_d = 1'b1;
               pad_d     = 1'b0;
               bidx_d    = 4'd0;
            end else begin
               m_tkeep_d = 8'hFF;
               m_tlast_d = 1'b0;
               bidx_d    = bidx_q + 4'd1;
            end
         end else
`endif
         if (avail) begin
            m_tvalid_d = 1'b1;
            out_ram_d  = 1'b1;
            ft_ptr_d   = ft_ptr_q + PTR_ONE;
            {m_tlast_d, m_tkeep_d, m_tdata_d} = rd_word;
`ifdef ETH_TX_PAD_EN
            // Bytes before the last beat are always full, so length < 60 means
            // the last beat sits below index 7, or at 7 with fewer than 4 bytes.
            if (!rd_word[72]) begin
               if (bidx_q != 4'd8) bidx_d = bidx_q + 4'd1;
            end else begin
               bidx_d = 4'd0;
               if (bidx_q < 4'd7) begin
                  m_tlast_d = 1'b0;
                  m_tkeep_d = 8'hFF;
                  m_tdata_d = rd_masked;
                  pad_d     = 1'b1;
                  bidx_d    = bidx_q + 4'd1;
               end else if ((bidx_q == 4'd7) && !rd_word[67]) begin
                  m_tkeep_d = 8'h0F;
                  m_tdata_d = rd_masked;
               end
            end
`endif
         end
      end
   end

   always_ff @(posedge eth_clk) begin
      if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= {s_tlast, s_tkeep, s_tdata};
   end

   always_ff @(posedge eth_clk or negedge eth_rst_n) begin
      if (!eth_rst_n) begin
         rx_state_q  <= RX_IDLE;
         wr_ptr_q    <= '0;
         wr_commit_q <= '0;
         rd_ptr_q    <= '0;
         ft_ptr_q    <= '0;
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
         m_tvalid_q  <= 1'b0;
         m_tlast_q   <= 1'b0;
         m_tkeep_q   <= '0;
         m_tdata_q   <= '0;
         out_ram_q   <= 1'b0;
`ifdef ETH_TX_PAD_EN
         pad_q       <= 1'b0;
         bidx_q      <= '0;
`endif
      end else begin
         rx_state_q  <= rx_state_d;
         wr_ptr_q    <= wr_ptr_d;
         wr_commit_q <= wr_commit_d;
         rd_ptr_q    <= rd_ptr_d;
         ft_ptr_q    <= ft_ptr_d;
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         m_tvalid_q  <= m_tvalid_d;
         m_tlast_q   <= m_tlast_d;
         m_tkeep_q   <= m_tkeep_d;
         m_tdata_q   <= m_tdata_d;
         out_ram_q   <= out_ram_d;
`ifdef ETH_TX_PAD_EN
         pad_q       <= pad_d;
         bidx_q      <= bidx_d;
`endif
      end
   end

   assign s_tready  = 1'b1;
   assign m_tvalid  = m_tvalid_q;
   assign m_tlast   = m_tlast_q;
   assign m_tkeep   = m_tkeep_q;
   assign m_tdata   = m_tdata_q;
   assign m_tuser   = 1'b0;
   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;
   assign buf_level = wr_commit_q - rd_ptr_q;

endmodule

// File: tb/tb_eth_tx_pktbuf.sv
// tb/tb_eth_tx_pktbuf.sv - table-driven bench for eth_tx_pktbuf at DEPTH=16
// Expected beats follow ETH_TX_PAD_EN when it is defined.
module tb_eth_tx_pktbuf;
   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);

   typedef logic [72:0] beat_t;
   typedef struct {
      int         nfr;
      int         n;
      logic [7:0] lk;
      int         mode;
      int         en;
      logic [7:0] elk;
      int         fcnt;
   } vec_t;

   logic          eth_clk = 1'b0;
   logic          eth_rst_n = 1'b1;
   logic          s_tvalid, s_tready, s_tlast;
   logic [7:0]    s_tkeep;
   logic [63:0]   s_tdata;
   logic          m_tvalid, m_tready, m_tlast, m_tuser;
   logic [7:0]    m_tkeep;
   logic [63:0]   m_tdata;
   logic [31:0]   frame_cnt, drop_cnt;
   logic [AW:0]   buf_level;

   int    errors = 0, checks = 0, cyc = 0, rdy_mode = 0;
   int    last_drv_cyc = 0, rise_cyc = 0, proto_err = 0, base = 0;
   beat_t outq[$];
   beat_t held;
   logic  held_v = 1'b0, vld_prev = 1'b0;
   vec_t  vt[7];

   always #5 eth_clk = ~eth_clk;

   eth_tx_pktbuf #(.DEPTH(DEPTH)) dut (
      .eth_clk(eth_clk), .eth_rst_n(eth_rst_n),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
      .s_tkeep(s_tkeep), .s_tdata(s_tdata),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .m_tkeep(m_tkeep), .m_tdata(m_tdata), .m_tuser(m_tuser),
      .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .buf_level(buf_level)
   );

   // Inputs change just after posedge, so the negedge view equals the next edge's handshake.
   always @(negedge eth_clk) begin
      if (!eth_rst_n) begin
         held_v   <= 1'b0;
         vld_prev <= 1'b0;
      end else begin
         if ((held_v && (!m_tvalid || ({m_tlast, m_tkeep, m_tdata} != held))) || m_tuser)
            proto_err <= proto_err + 1;
         held_v   <= m_tvalid && !m_tready;
         held     <= {m_tlast, m_tkeep, m_tdata};
         vld_prev <= m_tvalid;
         if (m_tvalid && !vld_prev) rise_cyc <= cyc;
         if (m_tvalid && m_tready) outq.push_back({m_tlast, m_tkeep, m_tdata});
      end
   end

   task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge eth_clk);
      #1;
      cyc++;
      case (rdy_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = ~m_tready;
         default: m_tready = 1'b0;
      endcase
   endtask

   function automatic logic [63:0] beat_data(input int seed, input int i);
      return {8'(seed), 8'(i), 16'hC35A, 32'(seed * 7919 + i * 131)};
   endfunction

   function automatic beat_t exp_beat(input int n, input logic [7:0] lk, input int seed,
                                      input int en, input logic [7:0] elk, input int i);
      logic [63:0] d;
      bit          padded;
      padded = (en != n) || (elk != lk);
      d = (i < n) ? beat_data(seed, i) : 64'd0;
      if (padded && (i == n - 1)) begin
         for (int b = 0; b < 8; b++) if (!lk[b]) d[8*b +: 8] = 8'h00;
      end
      return {(i == en - 1), ((i == en - 1) ? elk : 8'hFF), d};
   endfunction

   task automatic send_frame(input int n, input logic [7:0] lk, input int seed, input bit with_last);
      for (int i = 0; i < n; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = beat_data(seed, i);
         s_tkeep  = (i == n - 1) ? lk : 8'hFF;
         s_tlast  = with_last && (i == n - 1);
         if (s_tlast) last_drv_cyc = cyc;
         tick();
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic wait_out(input int want);
      int budget = 0;
      while ((outq.size() - base < want) && (budget < 400)) begin
         tick();
         budget++;
      end
      repeat (4) tick();
      chk("beat_count", 73'(outq.size() - base), 73'(want));
   endtask

   task automatic check_beats(input int nfr, input int n, input logic [7:0] lk,
                              input int seed, input int en, input logic [7:0] elk);
      int    k;
      beat_t act;
      k = base;
      for (int f = 0; f < nfr; f++) begin
         for (int i = 0; i < en; i++) begin
            act = (k < outq.size()) ? outq[k] : '0;
            chk($sformatf("beat seed%0d i%0d", seed + f, i), act,
                exp_beat(n, lk, seed + f, en, elk, i));
            k++;
         end
      end
   endtask

   initial begin
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = '0; s_tdata = '0; m_tready = 1'b1;

      vt[0] = '{3, 6, 8'hFF, 1, 6, 8'hFF, 4};
      vt[3] = '{1, 16, 8'hFF, 0, 16, 8'hFF, 8};
      vt[6] = '{1, 8, 8'h0F, 0, 8, 8'h0F, 11};
`ifdef ETH_TX_PAD_EN
      vt[1] = '{1, 1, 8'h01, 0, 8, 8'h0F, 5};
      vt[2] = '{2, 3, 8'h3F, 1, 8, 8'h0F, 7};
      vt[4] = '{1, 5, 8'h03, 0, 8, 8'h0F, 9};
      vt[5] = '{1, 8, 8'h07, 1, 8, 8'h0F, 10};
`else
      vt[1] = '{1, 1, 8'h01, 0, 1, 8'h01, 5};
      vt[2] = '{2, 3, 8'h3F, 1, 3, 8'h3F, 7};
      vt[4] = '{1, 5, 8'h03, 0, 5, 8'h03, 9};
      vt[5] = '{1, 8, 8'h07, 1, 8, 8'h07, 10};
`endif

      #2 eth_rst_n = 1'b0;
      #1;
      chk("rst_m_tvalid", 73'(m_tvalid), 73'(0));
      chk("rst_m_tlast", 73'(m_tlast), 73'(0));
      chk("rst_m_tkeep", 73'(m_tkeep), 73'(0));
      chk("rst_m_tdata", 73'(m_tdata), 73'(0));
      chk("rst_m_tuser", 73'(m_tuser), 73'(0));
      chk("rst_frame_cnt", 73'(frame_cnt), 73'(0));
      chk("rst_drop_cnt", 73'(drop_cnt), 73'(0));
      chk("rst_buf_level", 73'(buf_level), 73'(0));
      chk("rst_s_tready", 73'(s_tready), 73'(1));
      repeat (2) tick();
      eth_rst_n = 1'b1;
      tick();

      // single 6-beat frame: latency and content
      base = outq.size();
      send_frame(6, 8'hFF, 1, 1'b1);
      wait_out(6);
      chk("first_valid_latency", 73'(rise_cyc - last_drv_cyc), 73'(2));
      check_beats(1, 6, 8'hFF, 1, 6, 8'hFF);
      chk("frame_cnt_single", 73'(frame_cnt), 73'(1));

      for (int v = 0; v < 7; v++) begin
         rdy_mode = vt[v].mode;
         base = outq.size();
         for (int f = 0; f < vt[v].nfr; f++) send_frame(vt[v].n, vt[v].lk, 10 * (v + 1) + f, 1'b1);
         wait_out(vt[v].nfr * vt[v].en);
         check_beats(vt[v].nfr, vt[v].n, vt[v].lk, 10 * (v + 1), vt[v].en, vt[v].elk);
         chk($sformatf("vec%0d_frame_cnt", v), 73'(frame_cnt), 73'(vt[v].fcnt));
         chk($sformatf("vec%0d_drop_cnt", v), 73'(drop_cnt), 73'(0));
         chk($sformatf("vec%0d_buf_level", v), 73'(buf_level), 73'(0));
      end

      // stalled MAC: second 10-beat frame does not fit
      rdy_mode = 2;
      tick();
      base = outq.size();
      send_frame(10, 8'hFF, 100, 1'b1);
      send_frame(10, 8'hFF, 101, 1'b1);
      repeat (3) tick();
      chk("full_buf_level", 73'(buf_level), 73'(10));
      chk("full_drop_cnt", 73'(drop_cnt), 73'(1));
      chk("full_m_tvalid", 73'(m_tvalid), 73'(1));
      rdy_mode = 0;
      wait_out(10);
      check_beats(1, 10, 8'hFF, 100, 10, 8'hFF);
      chk("full_frame_cnt", 73'(frame_cnt), 73'(12));
      chk("full_buf_level_drained", 73'(buf_level), 73'(0));

      // oversize frame dropped, next frame intact
      base = outq.size();
      send_frame(20, 8'hFF, 110, 1'b1);
      repeat (10) tick();
      chk("oversize_no_out", 73'(outq.size() - base), 73'(0));
      chk("oversize_drop_cnt", 73'(drop_cnt), 73'(2));
      chk("oversize_buf_level", 73'(buf_level), 73'(0));
      send_frame(4, 8'hFF, 111, 1'b1);
      wait_out(4);
      check_beats(1, 4, 8'hFF, 111, 4, 8'hFF);
      chk("after_oversize_frame_cnt", 73'(frame_cnt), 73'(13));

      // reset with a frame mid-output and another mid-input
      base = outq.size();
      send_frame(8, 8'hFF, 120, 1'b1);
      send_frame(3, 8'hFF, 121, 1'b0);
      chk("mid_output_beats", 73'(outq.size() - base), 73'(2));
      eth_rst_n = 1'b0;
      #1;
      chk("mrst_m_tvalid", 73'(m_tvalid), 73'(0));
      chk("mrst_m_tlast", 73'(m_tlast), 73'(0));
      chk("mrst_m_tdata", 73'(m_tdata), 73'(0));
      chk("mrst_frame_cnt", 73'(frame_cnt), 73'(0));
      chk("mrst_drop_cnt", 73'(drop_cnt), 73'(0));
      chk("mrst_buf_level", 73'(buf_level), 73'(0));
      repeat (2) tick();
      eth_rst_n = 1'b1;
      tick();
      base = outq.size();
      send_frame(3, 8'hFF, 130, 1'b1);
      wait_out(3);
      check_beats(1, 3, 8'hFF, 130, 3, 8'hFF);
      chk("post_rst_frame_cnt", 73'(frame_cnt), 73'(1));
      chk("post_rst_drop_cnt", 73'(drop_cnt), 73'(0));

      chk("stall_stable_tuser", 73'(proto_err), 73'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
